avalon_pipelined_ram: RTL and testbench

// - Parametrised Avalon-MM slave on-chip RAM for the SoC data/instruction memories.
// - Adds over the fixed single-port memory:
//   - configurable width, depth and read latency;
//   - read/readdatavalid pipelining;
//   - waitrequest back-pressure;
//   - hardware zero-clear sequence after reset.
// - Sits on the system interconnect as a memory-mapped slave; one clock domain.

---
 rtl/avalon_ram_pkg.sv | 16 +
 rtl/avalon_ram_core.sv | 27 ++
 rtl/avalon_pipelined_ram.sv | 91 +++++++++
 tb/tb_avalon_pipelined_ram.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_ram_pkg.sv
// avalon_ram_pkg: shared state type and elaboration helpers for the pipelined Avalon RAM.
package avalon_ram_pkg;
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit latency_ok(input int lat);
        return lat == 1 || lat == 2;
    endfunction
endpackage

// File: rtl/avalon_ram_core.sv
// avalon_ram_core: inferred single-port RAM with per-byte write enables and a registered read port.
module avalon_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en)
            for (int i = 0; i < DATA_W / 8; i++)
                if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    // Read-before-write: a same-edge write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (en) rdata <= mem[addr];
    end
endmodule

// File: rtl/avalon_pipelined_ram.sv
// avalon_pipelined_ram: Avalon-MM slave RAM with read pipelining, back-pressure
// and a hardware zero-clear sequence after reset.
module avalon_pipelined_ram
    import avalon_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest
);
    localparam int BE_W = be_width(DATA_W);

    if (DATA_W % 8 != 0 || !latency_ok(READ_LATENCY)) begin : g_bad_params
        $error("avalon_pipelined_ram: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
    end

    state_t                    state;
    logic                      en, acc_rd, acc_wr, clearing;
    logic [ADDR_W-1:0]         clr_addr, ram_addr;
    logic [BE_W-1:0]           ram_we;
    logic [DATA_W-1:0]         ram_wdata, ram_rdata;
    logic [READ_LATENCY-1:0]   vld;

    assign en          = clken & ~reset_req;
    assign waitrequest = (state != ST_READY) | ~en;
    assign acc_wr      = chipselect & write & ~waitrequest;
    assign acc_rd      = chipselect & read & ~write & ~waitrequest;
    assign clearing    = state == ST_CLEAR;
    assign ram_addr    = clearing ? clr_addr : address;
    assign ram_we      = clearing ? {BE_W{1'b1}} : (acc_wr ? byteenable : '0);
    assign ram_wdata   = clearing ? '0 : writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RESET;
            clr_addr <= '0;
        end else if (state == ST_RESET) begin
            state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
        end else if (clearing && en) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= ST_READY;
        end
    end

    avalon_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clk   (clk),
        .rst   (reset),
        .en    (en),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Valid bits and data stages advance together, only on enabled cycles.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] out_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                vld   <= '0;
                out_q <= '0;
            end else if (en) begin
                vld   <= {vld[0], acc_rd};
                out_q <= ram_rdata;
            end
        end
        assign readdata = out_q;
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) vld <= '0;
            else if (en) vld <= acc_rd;
        end
        assign readdata = ram_rdata;
    end

    assign readdatavalid = vld[READ_LATENCY-1] & en;
endmodule

// File: tb/tb_avalon_pipelined_ram.sv
// tb_avalon_pipelined_ram: drives latency-1 and latency-2 instances in lockstep against a
// reference model that tracks memory contents and due times of reads in enabled cycles.
module tb_avalon_pipelined_ram;
    logic        clk = 0;
    logic        reset = 1, reset_req = 0, clken = 1;
    logic [3:0]  address = '0;
    logic [3:0]  byteenable = '0;
    logic        chipselect = 0, read = 0, write = 0;
    logic [31:0] writedata = '0;
    logic [31:0] rd1, rd2;
    logic        rdv1, rdv2, wr1, wr2;

    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    logic [31:0] mem [16];
    rd_t         q1[$], q2[$];
    int          ecnt = 0, pend = 1, clr_left = 16, pulses2 = 0;

    always #5 clk = ~clk;

    avalon_pipelined_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1));

    avalon_pipelined_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        logic en, rdy, ev;
        @(negedge clk);
        en  = clken & ~reset_req;
        rdy = pend == 0 && clr_left == 0;
        if (rdv2) pulses2++;
        if (reset) begin
            q1.delete();
            q2.delete();
            pend = 1;
            clr_left = 16;
            foreach (mem[i]) mem[i] = '0;
        end else begin
            if (en) ecnt++;
            chk("wait_l1", {31'b0, wr1}, {31'b0, !(rdy && en)});
            chk("wait_l2", {31'b0, wr2}, {31'b0, !(rdy && en)});
            ev = q1.size() > 0 && en && q1[0].due == ecnt;
            chk("rdv_l1", {31'b0, rdv1}, {31'b0, ev});
            if (ev) begin
                chk("data_l1", rd1, q1[0].data);
                void'(q1.pop_front());
            end
            ev = q2.size() > 0 && en && q2[0].due == ecnt;
            chk("rdv_l2", {31'b0, rdv2}, {31'b0, ev});
            if (ev) begin
                chk("data_l2", rd2, q2[0].data);
                void'(q2.pop_front());
            end
            if (rdy && en && chipselect) begin
                if (write) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) mem[address][b*8 +: 8] = writedata[b*8 +: 8];
                end else if (read) begin
                    q1.push_back('{mem[address], ecnt + 1});
                    q2.push_back('{mem[address], ecnt + 2});
                end
            end
            if (pend != 0) pend = 0;
            else if (clr_left > 0 && en) clr_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 0; read = 0; write = 0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1; read = 0; write = 1; address = a; writedata = d; byteenable = be;
        step();
        idle();
    endtask

    task automatic do_read(input logic [3:0] a);
        chipselect = 1; read = 1; write = 0; address = a;
        step();
        idle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset_and_count(input string tag);
        int cnt;
        reset = 1;
        step();
        step();
        reset = 0;
        cnt = 0;
        while (wr1 && cnt < 100) begin
            cnt++;
            step();
        end
        chk(tag, cnt, 17);
    endtask

    initial begin
        int cnt, p0;
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("rst_rd_l1", rd1, 32'h0);
        chk("rst_rd_l2", rd2, 32'h0);
        chk("rst_rdv", {30'b0, rdv1, rdv2}, 32'h0);
        chk("rst_wait", {30'b0, wr1, wr2}, 32'h3);
        cnt = 0;
        while (wr1 && cnt < 100) begin
            cnt++;
            step();
        end
        chk("clear_cycles", cnt, 17);
        for (int a = 0; a < 16; a++) do_read(4'(a));
        drain(4);

        do_write(4'd5, 32'hDEADBEEF, 4'b1111);
        do_write(4'd5, 32'h11223344, 4'b0101);
        do_read(4'd5);
        cnt = 0;
        while (!rdv1 && cnt < 8) begin
            cnt++;
            step();
        end
        chk("be_merge", rdv1 ? rd1 : 32'hBAD0BAD0, 32'hDE22BE44);
        drain(3);

        do_write(4'd1, 32'hA, 4'hF);
        do_write(4'd2, 32'hB, 4'hF);
        do_write(4'd3, 32'hC, 4'hF);
        do_read(4'd1);
        do_read(4'd2);
        do_read(4'd3);
        drain(4);

        do_read(4'd1);
        do_read(4'd2);
        p0 = pulses2;
        clken = 0;
        drain(3);
        chk("stall_hold", pulses2 - p0, 0);
        clken = 1;
        drain(4);
        chk("stall_once", pulses2 - p0, 2);

        chipselect = 1; read = 1; write = 1; address = 4'd7; writedata = 32'h55; byteenable = 4'hF;
        step();
        idle();
        drain(3);
        do_read(4'd7);
        drain(3);

        for (int a = 0; a < 16; a++) do_write(4'(a), 32'hFFFFFFFF, 4'hF);
        reset = 1;
        step();
        reset = 0;
        drain(10);
        do_reset_and_count("clear_restart");
        for (int a = 0; a < 16; a++) do_read(4'(a));
        drain(4);

        do_read(4'd3);
        p0 = pulses2;
        do_reset_and_count("reset_inflight_clear");
        chk("reset_drop_l2", pulses2 - p0, 0);

        for (int i = 0; i < 400; i++) begin
            chipselect = $urandom_range(0, 3) != 0;
            read       = $urandom_range(0, 1) == 1;
            write      = $urandom_range(0, 2) == 0;
            address    = 4'($urandom_range(0, 15));
            byteenable = 4'($urandom_range(0, 15));
            writedata  = $urandom;
            clken      = $urandom_range(0, 9) != 0;
            reset_req  = $urandom_range(0, 19) == 0;
            step();
        end
        idle();
        clken = 1;
        reset_req = 0;
        drain(4);
        chk("queues_empty", q1.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
